// File: rtl/msk_tweakey_rewind.sv
`default_nettype none
// ============================================================================
// Module   : msk_tweakey_rewind
// Purpose  : Masked SKINNY-128-256 tweakey schedule run backwards. Loads the
//            last-round masked TK1/TK2 state and emits round tweakeys in
//            reverse order (ROUNDS-1 down to 0), one per output handshake.
//            Each rewind step applies inverse LFSR2 to TK2 rows 0-1, then the
//            inverse cell permutation PT^-1 to TK1 and TK2. Every operation
//            is share-wise linear, so shares are never recombined.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready    - load handshake (ready only in IDLE)
//            tk1_in/tk2_in        - masked last-round TK1/TK2 (D*128 bits)
//            out_valid/out_ready  - round tweakey handshake
//            tk1_out/tk2_out      - masked TK1/TK2 of round round_idx
//            round_idx            - ROUNDS-1 down to 0
//            last                 - high with round_idx == 0
// Layout   : cell c (0..15) at bits [(16-c)*D*8-1 : (15-c)*D*8] (cell 0 at
//            MSB); share j of a cell at bits [j*8+7 : j*8] of that cell.
// Revision : 1.0 - initial release
// ============================================================================
module msk_tweakey_rewind #(
  parameter int D      = 2,
  parameter int ROUNDS = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D*128-1:0] tk1_in,
  input  logic [D*128-1:0] tk2_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D*128-1:0] tk1_out,
  output logic [D*128-1:0] tk2_out,
  output logic [7:0]       round_idx,
  output logic             last
);

  localparam int         c_cell_w   = D * 8;
  localparam logic [0:0] c_s_idle   = 1'b0;
  localparam logic [0:0] c_s_run    = 1'b1;
  localparam logic [7:0] c_last_idx = 8'(ROUNDS - 1);

  // Source cell of PT^-1: new cell i takes old cell pt_inv_src(i).
  function automatic int pt_inv_src(input int i);
    case (i)
      0:  return 8;
      1:  return 9;
      2:  return 10;
      3:  return 11;
      4:  return 12;
      5:  return 13;
      6:  return 14;
      7:  return 15;
      8:  return 2;
      9:  return 0;
      10: return 4;
      11: return 7;
      12: return 6;
      13: return 3;
      14: return 5;
      default: return 1;
    endcase
  endfunction

  logic [0:0]       r_state;
  logic [7:0]       r_cnt;
  logic [D*128-1:0] r_tk1;
  logic [D*128-1:0] r_tk2;

  logic [D*128-1:0] w_tk2_lfsr;
  logic [D*128-1:0] w_tk1_next;
  logic [D*128-1:0] w_tk2_next;

  // Inverse LFSR2 on every share byte of TK2 cells 0-7:
  // x7..x0 -> (x0^x6), x7, x6, x5, x4, x3, x2, x1
  for (genvar c = 0; c < 16; c++) begin : g_cell
    for (genvar j = 0; j < D; j++) begin : g_share
      localparam int LO = (15 - c) * c_cell_w + j * 8;
      if (c < 8) begin : g_lfsr
        assign w_tk2_lfsr[LO +: 8] = {r_tk2[LO] ^ r_tk2[LO + 6], r_tk2[LO + 7 -: 7]};
      end else begin : g_pass
        assign w_tk2_lfsr[LO +: 8] = r_tk2[LO +: 8];
      end
    end
  end

  // PT^-1 moves whole cells, so every share of a cell travels together.
  for (genvar c = 0; c < 16; c++) begin : g_perm_cell
    for (genvar j = 0; j < D; j++) begin : g_perm_share
      localparam int DST = (15 - c) * c_cell_w + j * 8;
      localparam int SRC = (15 - pt_inv_src(c)) * c_cell_w + j * 8;
      assign w_tk1_next[DST +: 8] = r_tk1[SRC +: 8];
      assign w_tk2_next[DST +: 8] = w_tk2_lfsr[SRC +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_s_idle;
      r_cnt   <= 8'd0;
      r_tk1   <= '0;
      r_tk2   <= '0;
    end else begin
      case (r_state)
        c_s_idle: begin
          if (in_valid) begin
            r_tk1   <= tk1_in;
            r_tk2   <= tk2_in;
            r_cnt   <= c_last_idx;
            r_state <= c_s_run;
          end
        end
        c_s_run: begin
          if (out_ready) begin
            if (r_cnt != 8'd0) begin
              r_tk1 <= w_tk1_next;
              r_tk2 <= w_tk2_next;
              r_cnt <= r_cnt - 8'd1;
            end else begin
              // Master tweakey delivered; registers keep their value.
              r_state <= c_s_idle;
            end
          end
        end
      endcase
    end
  end

  // All outputs come straight from registers: no path from the handshake
  // inputs to the tweakey data.
  assign in_ready  = (r_state == c_s_idle);
  assign out_valid = (r_state == c_s_run);
  assign last      = (r_state == c_s_run) && (r_cnt == 8'd0);
  assign round_idx = r_cnt;
  assign tk1_out   = r_tk1;
  assign tk2_out   = r_tk2;

endmodule
`default_nettype wire

// File: tb/tb_msk_tweakey_rewind.sv
`default_nettype none
// ============================================================================
// Module   : tb_msk_tweakey_rewind
// Purpose  : Self-checking bench for msk_tweakey_rewind. A cell-array model
//            of the SKINNY tweakey schedule (forward and backward) provides
//            every expected value, tracked per share and recombined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msk_tweakey_rewind;

  localparam int D      = 2;
  localparam int ROUNDS = 48;
  localparam int W      = D * 128;

  localparam int PINV [16] = '{8, 9, 10, 11, 12, 13, 14, 15, 2, 0, 4, 7, 6, 3, 5, 1};
  localparam int PT   [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] tk1_in;
  logic [W-1:0] tk2_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] tk1_out;
  logic [W-1:0] tk2_out;
  logic [7:0]   round_idx;
  logic         last;

  int tests_run    = 0;
  int tests_failed = 0;

  // Load values, per-share model state, unmasked model state, output history.
  logic [127:0] m1 [D];
  logic [127:0] m2 [D];
  logic [127:0] e1 [D];
  logic [127:0] e2 [D];
  logic [127:0] u1;
  logic [127:0] u2;
  logic [W-1:0] h1 [ROUNDS];
  logic [W-1:0] h2 [ROUNDS];

  always #5 clk = ~clk;

  msk_tweakey_rewind #(.D(D), .ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tk1_in    (tk1_in),
    .tk2_in    (tk2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tk1_out   (tk1_out),
    .tk2_out   (tk2_out),
    .round_idx (round_idx),
    .last      (last)
  );

  // ---------------- reference model (one share, cell array) ----------------
  function automatic logic [127:0] rewind_step(input logic [127:0] x, input bit is_tk2);
    logic [7:0]   c [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) c[i] = x[(15 - i) * 8 +: 8];
    if (is_tk2)
      for (int i = 0; i < 8; i++) c[i] = {c[i][0] ^ c[i][6], c[i][7:1]};
    for (int i = 0; i < 16; i++) r[(15 - i) * 8 +: 8] = c[PINV[i]];
    return r;
  endfunction

  function automatic logic [127:0] forward_step(input logic [127:0] x, input bit is_tk2);
    logic [7:0]   c [16];
    logic [7:0]   n [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) c[i] = x[(15 - i) * 8 +: 8];
    for (int i = 0; i < 16; i++) n[i] = c[PT[i]];
    if (is_tk2)
      for (int i = 0; i < 8; i++) n[i] = {n[i][6:0], n[i][7] ^ n[i][5]};
    for (int i = 0; i < 16; i++) r[(15 - i) * 8 +: 8] = n[i];
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input logic [127:0] s [D]);
    logic [W-1:0] b;
    for (int c = 0; c < 16; c++)
      for (int j = 0; j < D; j++)
        b[(15 - c) * D * 8 + j * 8 +: 8] = s[j][(15 - c) * 8 +: 8];
    return b;
  endfunction

  function automatic logic [127:0] share_of(input logic [W-1:0] b, input int j);
    logic [127:0] r;
    for (int c = 0; c < 16; c++) r[(15 - c) * 8 +: 8] = b[(15 - c) * D * 8 + j * 8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] recombine(input logic [W-1:0] b);
    logic [127:0] r = '0;
    for (int j = 0; j < D; j++) r ^= share_of(b, j);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Mask unmasked values v1/v2 into m1/m2 with fresh random shares.
  task automatic mask_values(input logic [127:0] v1, input logic [127:0] v2);
    m1[0] = v1;
    m2[0] = v2;
    for (int j = 1; j < D; j++) begin
      m1[j] = rnd128();
      m2[j] = rnd128();
      m1[0] ^= m1[j];
      m2[0] ^= m2[j];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_load();
    tk1_in   = pack(m1);
    tk2_in   = pack(m2);
    in_valid = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e1 = m1;
    e2 = m2;
    u1 = '0;
    u2 = '0;
    for (int j = 0; j < D; j++) begin
      u1 ^= m1[j];
      u2 ^= m2[j];
    end
  endtask

  // Consume the whole sequence, checking every presented output.
  task automatic drain(input bit rnd_ready, input bit hold_in);
    int idx = ROUNDS - 1;
    int n   = 0;
    int cyc = 0;
    bit rdy;
    while (n < ROUNDS && cyc < 4 * ROUNDS + 200) begin
      if (!rnd_ready)  rdy = 1'b1;
      else if (cyc < 4) rdy = (cyc == 0 || cyc == 3);
      else             rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (hold_in) begin
        in_valid = 1'b1;
        for (int k = 0; k < W / 32; k++) begin
          tk1_in[k * 32 +: 32] = $urandom();
          tk2_in[k * 32 +: 32] = $urandom();
        end
      end
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL run_flags: out_valid=%b in_ready=%b want 1/0 (idx %0d)",
                 out_valid, in_ready, idx);
        break;
      end
      tests_run++;
      if (round_idx !== 8'(idx) || last !== (idx == 0)) begin
        tests_failed++;
        $display("FAIL round_idx: got %0d last=%b want %0d last=%b",
                 round_idx, last, idx, (idx == 0));
      end
      tests_run++;
      if (tk1_out !== pack(e1) || tk2_out !== pack(e2)) begin
        tests_failed++;
        $display("FAIL shares idx %0d: tk1 %h tk2 %h want %h %h",
                 idx, tk1_out, tk2_out, pack(e1), pack(e2));
      end
      tests_run++;
      if (recombine(tk1_out) !== u1 || recombine(tk2_out) !== u2) begin
        tests_failed++;
        $display("FAIL recombine idx %0d: tk1 %h tk2 %h want %h %h",
                 idx, recombine(tk1_out), recombine(tk2_out), u1, u2);
      end
      if (rdy) begin
        h1[n] = tk1_out;
        h2[n] = tk2_out;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        n++;
        if (idx > 0) begin
          for (int j = 0; j < D; j++) begin
            e1[j] = rewind_step(e1[j], 1'b0);
            e2[j] = rewind_step(e2[j], 1'b1);
          end
          u1 = rewind_step(u1, 1'b0);
          u2 = rewind_step(u2, 1'b1);
        end
        idx--;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (n !== ROUNDS) begin
      tests_failed++;
      $display("FAIL transfer_count: got %0d want %0d", n, ROUNDS);
    end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL return_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || last !== 1'b0 || round_idx !== 8'd0 ||
        tk1_out !== '0 || tk2_out !== '0) begin
      tests_failed++;
      $display("FAIL %s: rdy=%b vld=%b last=%b idx=%0d tk1=%h tk2=%h want 1/0/0/0/zero",
               tag, in_ready, out_valid, last, round_idx, tk1_out, tk2_out);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    check_idle_zero("reset_state");
  endtask

  task automatic test_permutation();
    logic [127:0] base = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] p1   = 128'h08090A0B0C0D0E0F0200040706030501;
    m1[0] = base;
    m1[1] = '0;
    m2[0] = '0;
    m2[1] = '0;
    do_load();
    drain(1'b0, 1'b0);
    tests_run++;
    if (share_of(h1[0], 0) !== base) begin
      tests_failed++;
      $display("FAIL perm_out0: got %h want %h", share_of(h1[0], 0), base);
    end
    tests_run++;
    if (share_of(h1[1], 0) !== p1 || share_of(h1[1], 1) !== 128'h0) begin
      tests_failed++;
      $display("FAIL perm_out1: got %h/%h want %h/0", share_of(h1[1], 0), share_of(h1[1], 1), p1);
    end
    tests_run++;
    if (share_of(h1[16], 0) !== base) begin
      tests_failed++;
      $display("FAIL perm_order16: got %h want %h", share_of(h1[16], 0), base);
    end
  endtask

  task automatic test_lfsr();
    logic [127:0] want1 = {{8{8'h01}}, {8{8'h80}}};
    m1[0] = rnd128();
    m1[1] = rnd128();
    m2[0] = {16{8'h01}};
    m2[1] = '0;
    do_load();
    drain(1'b0, 1'b0);
    tests_run++;
    if (share_of(h2[1], 0) !== want1 || share_of(h2[1], 1) !== 128'h0) begin
      tests_failed++;
      $display("FAIL lfsr_out1: got %h/%h want %h/0", share_of(h2[1], 0), share_of(h2[1], 1), want1);
    end
  endtask

  task automatic test_masking();
    for (int t = 0; t < 2; t++) begin
      mask_values(rnd128(), rnd128());
      do_load();
      drain(1'b0, 1'b0);
    end
  endtask

  task automatic test_handshake();
    mask_values(rnd128(), rnd128());
    do_load();
    drain(1'b1, 1'b1);
  endtask

  task automatic test_reset_midrun();
    int cyc = 0;
    mask_values(rnd128(), rnd128());
    do_load();
    out_ready = 1'b1;
    while (round_idx !== 8'd20 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (round_idx !== 8'd20) begin
      tests_failed++;
      $display("FAIL midrun_reach: round_idx=%0d want 20", round_idx);
    end
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_zero("reset_midrun_async");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("reset_midrun_after");
    mask_values(rnd128(), rnd128());
    do_load();
    drain(1'b1, 1'b0);
  endtask

  task automatic test_round_trip();
    logic [127:0] t1 = 128'h009cec81605d4ac1d2ae9e3085d7a1f3;
    logic [127:0] t2 = 128'h1ac123ebfc00fddcf01046ceeddfcab3;
    logic [127:0] f1 = t1;
    logic [127:0] f2 = t2;
    for (int r = 0; r < ROUNDS - 1; r++) begin
      f1 = forward_step(f1, 1'b0);
      f2 = forward_step(f2, 1'b1);
    end
    mask_values(f1, f2);
    do_load();
    drain(1'b1, 1'b0);
    tests_run++;
    if (recombine(h1[ROUNDS - 1]) !== t1 || recombine(h2[ROUNDS - 1]) !== t2) begin
      tests_failed++;
      $display("FAIL round_trip: got %h/%h want %h/%h",
               recombine(h1[ROUNDS - 1]), recombine(h2[ROUNDS - 1]), t1, t2);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tk1_in    = '0;
    tk2_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_permutation();
    test_lfsr();
    test_masking();
    test_handshake();
    test_reset_midrun();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
